// File: rtl/mc_cpu_core.sv
// Parametrised multicycle CPU core with a unified word-addressed memory behind a
// req/ready handshake; adds jal, halt, illegal-opcode trapping and a retire counter.
module mc_cpu_core #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 16,
    parameter int                NREGS    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = {ADDR_W{1'b0}}
) (
    input  logic              clock,
    input  logic              reset,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [2:0]        state,
    output logic              halted,
    output logic              illegal,
    output logic [31:0]       instret
);
    localparam int REG_AW = $clog2(NREGS);

    localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04;
    localparam logic [5:0] OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_HALT = 6'h3F;
    localparam logic [5:0] FN_ADD = 6'h20, FN_SUB = 6'h22, FN_AND = 6'h24, FN_OR = 6'h25, FN_SLT = 6'h2A;
    localparam logic [ADDR_W-1:0] PC_ONE   = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [REG_AW-1:0] LINK_REG = {REG_AW{1'b1}};

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd5,
        S_TRAP   = 3'd6
    } state_t;

    state_t              r_state, w_next;
    logic [ADDR_W-1:0]   r_pc;
    logic [31:0]         r_ir;
    logic [DATA_W-1:0]   r_a, r_b, r_alu;
    logic [31:0]         r_instret;
    logic [DATA_W-1:0]   r_regs [NREGS];

    logic [5:0]          w_op, w_funct;
    logic [15:0]         w_imm;
    logic [REG_AW-1:0]   w_rs, w_rt, w_rd, w_dest;
    logic [DATA_W-1:0]   w_simm, w_alu;
    logic [ADDR_W-1:0]   w_pc1, w_br_off;
    logic                w_legal, w_retire;

    assign w_op     = r_ir[31:26];
    assign w_funct  = r_ir[5:0];
    assign w_imm    = r_ir[15:0];
    assign w_rs     = r_ir[21 +: REG_AW];
    assign w_rt     = r_ir[16 +: REG_AW];
    assign w_rd     = r_ir[11 +: REG_AW];
    assign w_dest   = (w_op == OP_RTYPE) ? w_rd : w_rt;
    assign w_simm   = DATA_W'($signed(w_imm));
    assign w_br_off = ADDR_W'($signed(w_imm));
    assign w_pc1    = r_pc + PC_ONE;

    // Opcode/funct legality check used by DECODE
    always_comb begin
        w_legal = 1'b0;
        case (w_op)
            OP_RTYPE: begin
                case (w_funct)
                    FN_ADD, FN_SUB, FN_AND, FN_OR, FN_SLT: w_legal = 1'b1;
                    default:                               w_legal = 1'b0;
                endcase
            end
            OP_J, OP_JAL, OP_BEQ, OP_ADDI, OP_LW, OP_SW, OP_HALT: w_legal = 1'b1;
            default:                                              w_legal = 1'b0;
        endcase
    end

    // R-type ALU
    always_comb begin
        w_alu = {DATA_W{1'b0}};
        case (w_funct)
            FN_ADD:  w_alu = r_a + r_b;
            FN_SUB:  w_alu = r_a - r_b;
            FN_AND:  w_alu = r_a & r_b;
            FN_OR:   w_alu = r_a | r_b;
            FN_SLT:  w_alu = DATA_W'($signed(r_a) < $signed(r_b));
            default: w_alu = {DATA_W{1'b0}};
        endcase
    end

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and retirement decode
    always_comb begin
        w_next   = r_state;
        w_retire = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (mem_ready) w_next = S_DECODE;
                else           w_next = S_FETCH;
            end
            S_DECODE: begin
                if (!w_legal) begin
                    w_next = S_TRAP;
                end else if (w_op == OP_HALT) begin
                    w_next   = S_HALT;
                    w_retire = 1'b1;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_op)
                    OP_RTYPE, OP_ADDI: w_next = S_WB;
                    OP_LW, OP_SW:      w_next = S_MEM;
                    default: begin
                        w_next   = S_FETCH;
                        w_retire = 1'b1;
                    end
                endcase
            end
            S_MEM: begin
                if (!mem_ready) begin
                    w_next = S_MEM;
                end else if (w_op == OP_LW) begin
                    w_next = S_WB;
                end else begin
                    w_next   = S_FETCH;
                    w_retire = 1'b1;
                end
            end
            S_WB: begin
                w_next   = S_FETCH;
                w_retire = 1'b1;
            end
            S_HALT:  w_next = S_HALT;
            S_TRAP:  w_next = S_TRAP;
            default: w_next = S_FETCH;
        endcase
    end

    // Datapath: IR, operand latches, ALU/EA/load result, PC, register file, retire count
    always_ff @(posedge clock) begin
        if (reset) begin
            r_pc      <= RESET_PC;
            r_ir      <= 32'd0;
            r_a       <= {DATA_W{1'b0}};
            r_b       <= {DATA_W{1'b0}};
            r_alu     <= {DATA_W{1'b0}};
            r_instret <= 32'd0;
            for (int i = 0; i < NREGS; i++) r_regs[i] <= {DATA_W{1'b0}};
        end else begin
            if (w_retire) r_instret <= r_instret + 32'd1;
            case (r_state)
                S_FETCH: if (mem_ready) r_ir <= 32'(mem_rdata);
                S_DECODE: begin
                    r_a <= r_regs[w_rs];
                    r_b <= r_regs[w_rt];
                end
                S_EXEC: begin
                    case (w_op)
                        OP_RTYPE:            r_alu <= w_alu;
                        OP_ADDI, OP_LW, OP_SW: r_alu <= r_a + w_simm;
                        OP_BEQ:              r_pc  <= (r_a == r_b) ? (w_pc1 + w_br_off) : w_pc1;
                        OP_J:                r_pc  <= r_ir[ADDR_W-1:0];
                        OP_JAL: begin
                            r_pc             <= r_ir[ADDR_W-1:0];
                            r_regs[LINK_REG] <= DATA_W'(w_pc1);
                        end
                        default: r_alu <= r_alu;
                    endcase
                end
                // the load result reuses r_alu once the address is no longer needed
                S_MEM: begin
                    if (mem_ready) begin
                        if (w_op == OP_LW) r_alu <= mem_rdata;
                        else               r_pc  <= w_pc1;
                    end
                end
                S_WB: begin
                    r_pc <= w_pc1;
                    if (w_dest != {REG_AW{1'b0}}) r_regs[w_dest] <= r_alu;
                end
                default: r_pc <= r_pc;
            endcase
        end
    end

    // Memory interface, decoded from registered state and held at zero during reset
    always_comb begin
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = {ADDR_W{1'b0}};
        mem_wdata = {DATA_W{1'b0}};
        if (!reset) begin
            case (r_state)
                S_FETCH: begin
                    mem_req  = 1'b1;
                    mem_addr = r_pc;
                end
                S_MEM: begin
                    mem_req  = 1'b1;
                    mem_addr = ADDR_W'(r_alu);
                    if (w_op == OP_SW) begin
                        mem_we    = 1'b1;
                        mem_wdata = r_b;
                    end else begin
                        mem_we = 1'b0;
                    end
                end
                default: mem_req = 1'b0;
            endcase
        end else begin
            mem_req = 1'b0;
        end
    end

    assign pc      = r_pc;
    assign state   = r_state;
    assign halted  = (r_state == S_HALT) || (r_state == S_TRAP);
    assign illegal = (r_state == S_TRAP);
    assign instret = r_instret;
endmodule

// File: tb/tb_mc_cpu_core.sv
// Self-checking bench for mc_cpu_core: one default-width core and one core with
// ADDR_W=8/NREGS=8, each with a wait-state memory model.
module tb_mc_cpu_core;
    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    logic        d0_req, d0_we, d0_ready, d0_halted, d0_illegal;
    logic [15:0] d0_addr, d0_pc;
    logic [31:0] d0_wdata, d0_rdata, d0_instret;
    logic [2:0]  d0_state;
    logic        d1_req, d1_we, d1_ready, d1_halted, d1_illegal;
    logic [7:0]  d1_addr, d1_pc;
    logic [31:0] d1_wdata, d1_rdata, d1_instret;
    logic [2:0]  d1_state;

    logic [31:0] prog0 [256];
    logic [31:0] prog1 [256];
    logic [31:0] dmem0 [64];
    logic [31:0] dmem1 [64];
    int cnt0 = 0, cnt1 = 0, waits0 = 0, waits1 = 0;

    int n_tests = 0, n_fail = 0;
    int stab_err, we_cnt, we_bad, cyc, dsel = 0;

    mc_cpu_core u_dut0 (
        .clock(clock), .reset(reset), .mem_req(d0_req), .mem_we(d0_we), .mem_addr(d0_addr),
        .mem_wdata(d0_wdata), .mem_rdata(d0_rdata), .mem_ready(d0_ready), .pc(d0_pc),
        .state(d0_state), .halted(d0_halted), .illegal(d0_illegal), .instret(d0_instret)
    );

    mc_cpu_core #(.DATA_W(32), .ADDR_W(8), .NREGS(8)) u_dut1 (
        .clock(clock), .reset(reset), .mem_req(d1_req), .mem_we(d1_we), .mem_addr(d1_addr),
        .mem_wdata(d1_wdata), .mem_rdata(d1_rdata), .mem_ready(d1_ready), .pc(d1_pc),
        .state(d1_state), .halted(d1_halted), .illegal(d1_illegal), .instret(d1_instret)
    );

    // memory map: words 0x40..0x7F are writable data, everything else is program
    assign d0_rdata = (d0_addr[7:6] == 2'b01) ? dmem0[d0_addr[5:0]] : prog0[d0_addr[7:0]];
    assign d1_rdata = (d1_addr[7:6] == 2'b01) ? dmem1[d1_addr[5:0]] : prog1[d1_addr];
    assign d0_ready = d0_req && (cnt0 == waits0);
    assign d1_ready = d1_req && (cnt1 == waits1);

    always @(posedge clock) begin
        if (!d0_req || d0_ready) cnt0 <= 0; else cnt0 <= cnt0 + 1;
        if (!d1_req || d1_ready) cnt1 <= 0; else cnt1 <= cnt1 + 1;
        if (d0_req && d0_ready && d0_we && d0_addr[7:6] == 2'b01) dmem0[d0_addr[5:0]] <= d0_wdata;
        if (d1_req && d1_ready && d1_we && d1_addr[7:6] == 2'b01) dmem1[d1_addr[5:0]] <= d1_wdata;
    end

    logic        cur_req, cur_we, cur_ready, cur_halted;
    logic [15:0] cur_addr;
    assign cur_req    = (dsel == 0) ? d0_req : d1_req;
    assign cur_we     = (dsel == 0) ? d0_we : d1_we;
    assign cur_ready  = (dsel == 0) ? d0_ready : d1_ready;
    assign cur_halted = (dsel == 0) ? d0_halted : d1_halted;
    assign cur_addr   = (dsel == 0) ? d0_addr : {8'h00, d1_addr};

    localparam logic [31:0] HALT_W = 32'hFC00_0000;

    function automatic logic [31:0] enc_i(input logic [5:0] op, input int rs, input int rt, input logic [15:0] imm);
        return {op, 5'(rs), 5'(rt), imm};
    endfunction
    function automatic logic [31:0] enc_r(input int rd, input int rs, input int rt, input logic [5:0] fn);
        return {6'h00, 5'(rs), 5'(rt), 5'(rd), 5'd0, fn};
    endfunction
    function automatic logic [31:0] enc_j(input logic [5:0] op, input int target);
        return {op, 26'(target)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic fill_progs();
        for (int i = 0; i < 256; i++) begin
            prog0[i] = HALT_W;
            prog1[i] = HALT_W;
        end
    endtask

    // assert reset for three cycles, release it on a falling edge
    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        repeat (3) @(negedge clock);
        reset = 1'b0;
    endtask

    // run the selected core until halted/trapped, tracking handshake stability
    task automatic run(input int budget, output int cycles);
        logic        pend, pwe;
        logic [15:0] paddr;
        pend = 1'b0; pwe = 1'b0; paddr = 16'h0000;
        cycles = 0; stab_err = 0; we_cnt = 0; we_bad = 0;
        while (cycles < budget && !cur_halted) begin
            @(posedge clock);
            #1;
            cycles++;
            if (pend && (!cur_req || cur_addr != paddr || cur_we != pwe)) stab_err++;
            if (cur_req && cur_we) begin
                we_cnt++;
                if (cur_addr != 16'h0040) we_bad++;
            end
            pend  = cur_req && !cur_ready;
            paddr = cur_addr;
            pwe   = cur_we;
        end
        check("halt_reached", {63'd0, cur_halted}, 64'd1);
    endtask

    typedef struct {
        logic [15:0] i1;
        logic [15:0] i2;
        logic [5:0]  fn;
        logic [31:0] exp;
        int          waits;
        int          cycles;
    } vec_t;
    vec_t vecs [8];

    initial begin
        vecs[0] = '{16'd5,    16'hFFFD, 6'h20, 32'd2,         0, 14};
        vecs[1] = '{16'd5,    16'hFFFD, 6'h20, 32'd2,         2, 22};
        vecs[2] = '{16'd5,    16'd7,    6'h22, 32'hFFFF_FFFE, 0, 14};
        vecs[3] = '{16'hFFFF, 16'h1234, 6'h24, 32'h0000_1234, 1, 18};
        vecs[4] = '{16'h8000, 16'h0001, 6'h25, 32'hFFFF_8001, 0, 14};
        vecs[5] = '{16'hFFFF, 16'h0001, 6'h2A, 32'd1,         0, 14};
        vecs[6] = '{16'h0001, 16'hFFFF, 6'h2A, 32'd0,         0, 14};
        vecs[7] = '{16'h7FFF, 16'h7FFF, 6'h20, 32'h0000_FFFE, 0, 14};

        fill_progs();
        repeat (3) @(negedge clock);
        check("rst_req",     {63'd0, d0_req},     64'd0);
        check("rst_we",      {63'd0, d0_we},      64'd0);
        check("rst_addr",    {48'd0, d0_addr},    64'd0);
        check("rst_wdata",   {32'd0, d0_wdata},   64'd0);
        check("rst_pc",      {48'd0, d0_pc},      64'd0);
        check("rst_state",   {61'd0, d0_state},   64'd0);
        check("rst_instret", {32'd0, d0_instret}, 64'd0);
        check("rst_halted",  {63'd0, d0_halted},  64'd0);
        check("rst_illegal", {63'd0, d0_illegal}, 64'd0);

        // table: r1 = i1, r2 = i2, r3 = r1 fn r2, halt
        dsel = 0;
        for (int i = 0; i < 8; i++) begin
            fill_progs();
            prog0[0] = enc_i(6'h08, 0, 1, vecs[i].i1);
            prog0[1] = enc_i(6'h08, 0, 2, vecs[i].i2);
            prog0[2] = enc_r(3, 1, 2, vecs[i].fn);
            waits0 = vecs[i].waits;
            do_reset();
            run(200, cyc);
            check($sformatf("vec%0d_r3", i),      {32'd0, u_dut0.r_regs[3]}, {32'd0, vecs[i].exp});
            check($sformatf("vec%0d_instret", i), {32'd0, d0_instret},       64'd4);
            check($sformatf("vec%0d_cycles", i),  64'(cyc),                  64'(vecs[i].cycles));
            check($sformatf("vec%0d_stable", i),  64'(stab_err),             64'd0);
        end
        waits0 = 0;

        // store then load through data memory
        fill_progs();
        prog0[0] = enc_i(6'h08, 0, 1, 16'd7);
        prog0[1] = enc_i(6'h2B, 0, 1, 16'h0040);
        prog0[2] = enc_i(6'h23, 0, 2, 16'h0040);
        do_reset();
        run(200, cyc);
        check("ls_mem",     {32'd0, dmem0[0]},         64'd7);
        check("ls_r2",      {32'd0, u_dut0.r_regs[2]}, 64'd7);
        check("ls_instret", {32'd0, d0_instret},       64'd4);
        check("ls_cycles",  64'(cyc),                  64'd15);
        check("ls_we_cnt",  64'(we_cnt),               64'd1);
        check("ls_we_addr", 64'(we_bad),               64'd0);

        // illegal opcode at PC 3, with a discarded write to r0 first
        fill_progs();
        prog0[0] = enc_i(6'h08, 0, 0, 16'd9);
        prog0[1] = enc_i(6'h08, 0, 1, 16'd1);
        prog0[2] = enc_i(6'h08, 0, 2, 16'd2);
        prog0[3] = enc_j(6'h3E, 0);
        do_reset();
        run(200, cyc);
        check("trap_illegal", {63'd0, d0_illegal},     64'd1);
        check("trap_pc",      {48'd0, d0_pc},          64'd3);
        check("trap_instret", {32'd0, d0_instret},     64'd3);
        check("trap_cycles",  64'(cyc),                64'd14);
        check("trap_r0",      {32'd0, u_dut0.r_regs[0]}, 64'd0);
        repeat (3) @(posedge clock);
        #1;
        check("trap_hold_state", {61'd0, d0_state}, 64'd6);
        check("trap_hold_pc",    {48'd0, d0_pc},    64'd3);

        // narrow core: beq wraps PC 0 -> 0xFF, j 5, jal 0x20 links into r7
        fill_progs();
        prog1[0]    = enc_i(6'h04, 0, 0, 16'hFFFE);
        prog1[255]  = enc_j(6'h02, 5);
        prog1[5]    = enc_j(6'h03, 32'h20);
        dsel = 1;
        do_reset();
        repeat (3) @(posedge clock);
        #1;
        check("beq_wrap_pc",      {56'd0, d1_pc},      64'hFF);
        check("beq_wrap_instret", {32'd0, d1_instret}, 64'd1);
        check("beq_wrap_state",   {61'd0, d1_state},   64'd0);
        run(100, cyc);
        check("jal_pc",      {56'd0, d1_pc},            64'h20);
        check("jal_link",    {32'd0, u_dut1.r_regs[7]}, 64'd6);
        check("jal_instret", {32'd0, d1_instret},       64'd4);
        check("jal_cycles",  64'(cyc),                  64'd8);
        check("jal_illegal", {63'd0, d1_illegal},       64'd0);

        // reset while a fetch is waiting on ready
        dsel = 0;
        fill_progs();
        prog0[0] = enc_i(6'h08, 0, 1, 16'd5);
        prog0[1] = enc_i(6'h08, 0, 2, 16'd6);
        waits0 = 3;
        do_reset();
        for (int k = 0; k < 40 && d0_instret != 32'd1; k++) begin
            @(posedge clock);
            #1;
        end
        check("mr_first_retire", {32'd0, d0_instret}, 64'd1);
        @(posedge clock);
        #1;
        check("mr_waiting_req", {63'd0, d0_req}, 64'd1);
        check("mr_waiting_pc",  {48'd0, d0_pc},  64'd1);
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
        check("mr_req",     {63'd0, d0_req},           64'd0);
        check("mr_pc",      {48'd0, d0_pc},            64'd0);
        check("mr_instret", {32'd0, d0_instret},       64'd0);
        check("mr_state",   {61'd0, d0_state},         64'd0);
        check("mr_r1",      {32'd0, u_dut0.r_regs[1]}, 64'd0);
        @(negedge clock);
        reset = 1'b0;
        #1;
        check("mr_restart_req",  {63'd0, d0_req},  64'd1);
        check("mr_restart_addr", {48'd0, d0_addr}, 64'd0);
        run(200, cyc);
        check("mr_r2",      {32'd0, u_dut0.r_regs[2]}, 64'd6);
        check("mr_final",   {32'd0, d0_instret},       64'd3);
        check("mr_stable",  64'(stab_err),             64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
